// File: rtl/irrigation_zone_scheduler.sv
// Round-robin scheduler that lets one irrigation zone valve open at a time, with a fixed watering and settle pause.
// Optional rain lockout (rain input, grant inhibit, watering truncation) is built when RAIN_LOCKOUT_EN is defined.
module irrigation_zone_scheduler #(
    parameter int N_ZONES      = 4,
    parameter int WATER_CYCLES = 100,
    parameter int PAUSE_CYCLES = 50,
    parameter int CNT_W        = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_ZONES-1:0]         req,
    input  logic                       abort,
`ifdef RAIN_LOCKOUT_EN
    input  logic                       rain,
`endif
    output logic [N_ZONES-1:0]         valve_open,
    output logic [$clog2(N_ZONES)-1:0] active_zone,
    output logic [N_ZONES-1:0]         pending,
    output logic                       busy,
    output logic                       zone_done,
    output logic [1:0]                 dbg_state
);
    localparam int ZW = $clog2(N_ZONES);
    localparam logic [CNT_W-1:0] WATER_LOAD = CNT_W'(WATER_CYCLES - 1);
    localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [ZW-1:0]    LAST_ZONE  = ZW'(N_ZONES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WATER = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   w_timer_next;
    logic [ZW-1:0]      r_last;
    logic [ZW-1:0]      w_sel;
    logic [ZW-1:0]      w_idx;
    logic               w_sel_valid;
    logic [N_ZONES-1:0] r_pending;
    logic [N_ZONES-1:0] w_pending_next;
    logic [N_ZONES-1:0] w_grant_mask;
    logic [N_ZONES-1:0] w_rearm_mask;
    logic [N_ZONES-1:0] r_valve_open;
    logic [N_ZONES-1:0] w_valve_next;
    logic               r_zone_done;
    logic               w_done_next;
    logic               w_grant;
    logic               w_to_pause;
    logic               w_truncate;
    logic               w_rain;

`ifdef RAIN_LOCKOUT_EN
    assign w_rain = rain;
`else
    assign w_rain = 1'b0;
`endif

    // Smallest offset from last+1 must win, so offsets are scanned downward and later hits overwrite.
    always_comb begin
        w_sel       = r_last;
        w_sel_valid = 1'b0;
        w_idx       = '0;
        for (int i = N_ZONES; i >= 1; i--) begin
            w_idx = ZW'((int'(r_last) + i) % N_ZONES);
            if (r_pending[w_idx]) begin
                w_sel       = w_idx;
                w_sel_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_last       <= LAST_ZONE;
            r_pending    <= '0;
            r_valve_open <= '0;
            r_zone_done  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_timer      <= w_timer_next;
            r_pending    <= w_pending_next;
            r_valve_open <= w_valve_next;
            r_zone_done  <= w_done_next;
            if (w_grant) begin
                r_last <= w_sel;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_to_pause   = 1'b0;
        w_truncate   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!abort && !w_rain && w_sel_valid) begin
                    w_next_state = S_WATER;
                    w_grant      = 1'b1;
                end
            end
            S_WATER: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_rain) begin
                    w_next_state = S_PAUSE;
                    w_to_pause   = 1'b1;
                    w_truncate   = 1'b1;
                end else if (r_timer == '0) begin
                    w_next_state = S_PAUSE;
                    w_to_pause   = 1'b1;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (r_timer == '0) begin
                    if (!w_rain && w_sel_valid) begin
                        w_next_state = S_WATER;
                        w_grant      = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // A truncated watering re-arms its own zone so it is served again once the lockout lifts.
    always_comb begin
        w_grant_mask   = w_grant ? (N_ZONES'(1) << w_sel) : '0;
        w_rearm_mask   = w_truncate ? (N_ZONES'(1) << r_last) : '0;
        w_pending_next = abort ? '0 : ((r_pending | req | w_rearm_mask) & ~w_grant_mask);
        w_valve_next   = '0;
        if (w_next_state == S_WATER) begin
            w_valve_next = w_grant ? w_grant_mask : r_valve_open;
        end
        w_done_next = w_to_pause && !w_truncate;
        if (w_grant) begin
            w_timer_next = WATER_LOAD;
        end else if (w_to_pause) begin
            w_timer_next = PAUSE_LOAD;
        end else if (r_timer != '0) begin
            w_timer_next = r_timer - 1'b1;
        end else begin
            w_timer_next = '0;
        end
    end

    assign valve_open  = r_valve_open;
    assign active_zone = r_last;
    assign pending     = r_pending;
    assign zone_done   = r_zone_done;
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed bench for irrigation_zone_scheduler with N_ZONES=4, WATER_CYCLES=10, PAUSE_CYCLES=5.
// The rain lockout sequence is included when RAIN_LOCKOUT_EN is defined.
module tb_irrigation_zone_scheduler;
    localparam int N = 4;
    localparam int W = 10;
    localparam int P = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       abort;
`ifdef RAIN_LOCKOUT_EN
    logic       rain;
`endif
    logic [3:0] valve_open;
    logic [1:0] active_zone;
    logic [3:0] pending;
    logic       busy;
    logic       zone_done;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    irrigation_zone_scheduler #(
        .N_ZONES(N), .WATER_CYCLES(W), .PAUSE_CYCLES(P), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .abort(abort),
`ifdef RAIN_LOCKOUT_EN
        .rain(rain),
`endif
        .valve_open(valve_open),
        .active_zone(active_zone),
        .pending(pending),
        .busy(busy),
        .zone_done(zone_done),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       abort;
        int         hold;
        logic [3:0] valve;
        logic [3:0] pend;
        logic       busy;
        logic       done;
        logic [1:0] act;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] q, input logic a, input int h,
                                input logic [3:0] v, input logic [3:0] p, input logic b,
                                input logic d, input logic [1:0] z);
        vec_t e;
        e.rst = r; e.req = q; e.abort = a; e.hold = h;
        e.valve = v; e.pend = p; e.busy = b; e.done = d; e.act = z;
        vecs.push_back(e);
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic [3:0] q, input logic a, input logic r);
        req = q; abort = a; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] v, input logic [3:0] p,
                         input logic b, input logic d, input logic [1:0] z);
        logic [11:0] got;
        logic [11:0] exp;
        exp_q.push_back({v, p, b, d, z});
        got = {valve_open, pending, busy, zone_done, active_zone};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp || $countones(valve_open) > 1) begin
            n_fail++;
            $display("FAIL %s @%0t: got valve=%b pend=%b busy=%b done=%b act=%0d, expected valve=%b pend=%b busy=%b done=%b act=%0d",
                     name, $time, valve_open, pending, busy, zone_done, active_zone,
                     exp[11:8], exp[7:4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b0, 1'b1);
        check("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; abort = 1'b0;
`ifdef RAIN_LOCKOUT_EN
        rain = 1'b0;
`endif
        // Single request from reset
        add(1, 4'b0000, 0, 1,  4'b0000, 4'b0000, 0, 0, 3);
        add(0, 4'b0100, 0, 1,  4'b0000, 4'b0100, 0, 0, 3);
        add(0, 4'b0000, 0, 10, 4'b0100, 4'b0000, 1, 0, 2);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b0000, 1, 1, 2);
        add(0, 4'b0000, 0, 4,  4'b0000, 4'b0000, 1, 0, 2);
        add(0, 4'b0000, 0, 2,  4'b0000, 4'b0000, 0, 0, 2);
        // Three zones from reset: order 0, 1, 3
        add(1, 4'b0000, 0, 1,  4'b0000, 4'b0000, 0, 0, 3);
        add(0, 4'b1011, 0, 1,  4'b0000, 4'b1011, 0, 0, 3);
        add(0, 4'b0000, 0, 10, 4'b0001, 4'b1010, 1, 0, 0);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b1010, 1, 1, 0);
        add(0, 4'b0000, 0, 4,  4'b0000, 4'b1010, 1, 0, 0);
        add(0, 4'b0000, 0, 10, 4'b0010, 4'b1000, 1, 0, 1);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b1000, 1, 1, 1);
        add(0, 4'b0000, 0, 4,  4'b0000, 4'b1000, 1, 0, 1);
        add(0, 4'b0000, 0, 10, 4'b1000, 4'b0000, 1, 0, 3);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b0000, 1, 1, 3);
        add(0, 4'b0000, 0, 4,  4'b0000, 4'b0000, 1, 0, 3);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b0000, 0, 0, 3);
        // Wrap from last=3: zone 0 before zone 3
        add(0, 4'b1001, 0, 1,  4'b0000, 4'b1001, 0, 0, 3);
        add(0, 4'b0000, 0, 10, 4'b0001, 4'b1000, 1, 0, 0);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b1000, 1, 1, 0);
        add(0, 4'b0000, 0, 4,  4'b0000, 4'b1000, 1, 0, 0);
        add(0, 4'b0000, 0, 10, 4'b1000, 4'b0000, 1, 0, 3);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b0000, 1, 1, 3);
        add(0, 4'b0000, 0, 4,  4'b0000, 4'b0000, 1, 0, 3);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b0000, 0, 0, 3);
        // Abort in IDLE clears pending; abort drops a same-cycle req
        add(0, 4'b0010, 0, 1,  4'b0000, 4'b0010, 0, 0, 3);
        add(0, 4'b0000, 1, 1,  4'b0000, 4'b0000, 0, 0, 3);
        add(0, 4'b0100, 1, 1,  4'b0000, 4'b0000, 0, 0, 3);
        add(0, 4'b0000, 0, 2,  4'b0000, 4'b0000, 0, 0, 3);
        // Re-request of the zone being watered serves it again
        add(1, 4'b0000, 0, 1,  4'b0000, 4'b0000, 0, 0, 3);
        add(0, 4'b0001, 0, 1,  4'b0000, 4'b0001, 0, 0, 3);
        add(0, 4'b0000, 0, 2,  4'b0001, 4'b0000, 1, 0, 0);
        add(0, 4'b0001, 0, 1,  4'b0001, 4'b0001, 1, 0, 0);
        add(0, 4'b0000, 0, 7,  4'b0001, 4'b0001, 1, 0, 0);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b0001, 1, 1, 0);
        add(0, 4'b0000, 0, 4,  4'b0000, 4'b0001, 1, 0, 0);
        add(0, 4'b0000, 0, 10, 4'b0001, 4'b0000, 1, 0, 0);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b0000, 1, 1, 0);
        add(0, 4'b0000, 0, 4,  4'b0000, 4'b0000, 1, 0, 0);
        add(0, 4'b0000, 0, 1,  4'b0000, 4'b0000, 0, 0, 0);

        for (int v = 0; v < vecs.size(); v++) begin
            for (int c = 0; c < vecs[v].hold; c++) begin
                step((c == 0) ? vecs[v].req : 4'b0000, (c == 0) ? vecs[v].abort : 1'b0,
                     (c == 0) ? vecs[v].rst : 1'b0);
                check($sformatf("vec%0d.%0d", v, c), vecs[v].valve, vecs[v].pend,
                      vecs[v].busy, vecs[v].done, vecs[v].act);
            end
        end
        rst = 1'b0;

        // Abort at watering cycle 6 of zone 1 with zone 2 pending
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        check("abort_pend1", 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd3);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);
        check("abort_pre", 4'b0010, 4'b0100, 1'b1, 1'b0, 2'd1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        check("abort_now", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 15; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            check("abort_quiet", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1);
        end
        step(4'b0011, 1'b0, 1'b0);
        check("abort_rr_pend", 4'b0000, 4'b0011, 1'b0, 1'b0, 2'd1);
        step(4'b0000, 1'b0, 1'b0);
        check("abort_rr_grant", 4'b0001, 4'b0010, 1'b1, 1'b0, 2'd0);

        // Reset during PAUSE, then a fresh request with 2-cycle latency
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check("rstp_pend", 4'b0001, 4'b0100, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 7; i++) step(4'b0000, 1'b0, 1'b0);
        check("rstp_done", 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd0);
        step(4'b0000, 1'b0, 1'b0);
        check("rstp_pause", 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd0);
        step(4'b0000, 1'b0, 1'b1);
        check("rstp_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3);
        step(4'b0000, 1'b0, 1'b0);
        check("rstp_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3);
        step(4'b0001, 1'b0, 1'b0);
        check("rstp_req", 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd3);
        step(4'b0000, 1'b0, 1'b0);
        check("rstp_valve", 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0);

`ifdef RAIN_LOCKOUT_EN
        // Rain at watering cycle 4 of zone 2 truncates and holds the zone pending
        do_reset();
        step(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b0);
        check("rain_pre", 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd2);
        rain = 1'b1;
        step(4'b0000, 1'b0, 1'b0);
        check("rain_cut", 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            check("rain_pause", 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2);
        end
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            check("rain_hold", 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd2);
        end
        rain = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            check("rain_rewater", 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd2);
        end
        step(4'b0000, 1'b0, 1'b0);
        check("rain_done", 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
